// File: rtl/nibble_race_capture_pkg.sv
// nibble_race_pkg: shared state encoding and default window parameters
package nibble_race_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} race_state_e;
  localparam int DEF_TIMEOUT = 10;
  localparam int DEF_BEATS = 4;
endpackage

// File: rtl/nibble_race_capture_if.sv
// nibble_race_capture_if: control, nibble input and result bundle for the capture block
interface nibble_race_capture_if import nibble_race_pkg::*; #(
  parameter int BEATS = DEF_BEATS
) ();
  localparam int SUM_W = $clog2(15 * BEATS + 1);
  localparam int CNT_W = $clog2(BEATS + 1);
  logic start;
  logic [3:0] in;
  logic in_valid;
  logic [SUM_W-1:0] sum;
  logic [CNT_W-1:0] count;
  logic busy;
  logic done;
  logic timed_out;
  modport master (output start, in, in_valid, input sum, count, busy, done, timed_out);
  modport slave (input start, in, in_valid, output sum, count, busy, done, timed_out);
endinterface

// File: rtl/nibble_race_capture_timer.sv
// race_timer: loadable down-counter flagging the last enabled cycle of a window
module race_timer import nibble_race_pkg::*; #(
  parameter int W = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic [W-1:0] load_val,
  input  logic en,
  input  logic cancel,
  output logic expired
);
  logic [W-1:0] cnt;
  assign expired = en && cnt == W'(1);
  // cancel parks the counter at zero so it can never flag expiry again
  always_ff @(posedge clk)
    if (rst || cancel) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (en && cnt != '0) cnt <= cnt - W'(1);
endmodule

// File: rtl/nibble_race_capture.sv
// nibble_race_capture: accumulates a nibble burst raced against a cycle timeout
module nibble_race_capture import nibble_race_pkg::*; #(
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int BEATS = DEF_BEATS
) (
  input logic clk,
  input logic rst,
  nibble_race_capture_if.slave bus
);
  localparam int SUM_W = $clog2(15 * BEATS + 1);
  localparam int CNT_W = $clog2(BEATS + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  race_state_e state;
  logic [SUM_W-1:0] sum;
  logic [CNT_W-1:0] count;
  logic busy, done, timed_out, expired, complete;
  assign complete = state == RUN && bus.in_valid && count == CNT_W'(BEATS - 1);
  assign bus.sum = sum;
  assign bus.count = count;
  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.timed_out = timed_out;
  race_timer #(.W(TW)) u_timer (
    .clk,
    .rst,
    .load(state == IDLE),
    .load_val(TW'(TIMEOUT)),
    .en(state == RUN),
    .cancel(complete),
    .expired
  );
  // window FSM; a final beat landing on the expiry cycle wins the race
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      sum <= '0;
      count <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      timed_out <= 1'b0;
    end else
      case (state)
        IDLE: if (bus.start) begin
          state <= RUN;
          busy <= 1'b1;
          sum <= '0;
          count <= '0;
          timed_out <= 1'b0;
        end
        RUN: begin
          if (bus.in_valid) begin
            sum <= sum + SUM_W'(bus.in);
            count <= count + CNT_W'(1);
          end
          if (complete || expired) begin
            state <= DONE;
            busy <= 1'b0;
            done <= 1'b1;
            timed_out <= !complete;
          end
        end
        default: begin
          state <= IDLE;
          done <= 1'b0;
        end
      endcase
endmodule

// File: tb/tb_nibble_race_capture.sv
// tb_nibble_race_capture: directed scenario checks for the nibble race capture block
module tb_nibble_race_capture;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;
  nibble_race_capture_if #(.BEATS(4)) bus ();
  nibble_race_capture #(.TIMEOUT(10), .BEATS(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.in = 4'd5;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    checks++;
    if ({bus.sum, bus.count, bus.busy, bus.done, bus.timed_out} !== '0) begin
      errors++;
      $display("FAIL reset: got sum=%0d count=%0d busy=%0b done=%0b to=%0b expected all 0",
               bus.sum, bus.count, bus.busy, bus.done, bus.timed_out);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_full_burst;
    int v[4] = '{3, 4, 5, 6};
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("burst_busy", int'(bus.busy), 1);
    foreach (v[i]) begin
      bus.in_valid = 1'b1;
      bus.in = 4'(v[i]);
      tick();
    end
    bus.in_valid = 1'b0;
    chk("burst_done", int'(bus.done), 1);
    chk("burst_sum", int'(bus.sum), 18);
    chk("burst_count", int'(bus.count), 4);
    chk("burst_to", int'(bus.timed_out), 0);
    chk("burst_busy_off", int'(bus.busy), 0);
    tick();
    chk("burst_done_width", int'(bus.done), 0);
    chk("burst_sum_hold", int'(bus.sum), 18);
  endtask

  task automatic test_timeout;
    int n = 0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      bus.in_valid = i <= 2;
      bus.in = i == 1 ? 4'd7 : 4'd8;
      tick();
      if (bus.done) begin
        n = i;
        break;
      end
    end
    bus.in_valid = 1'b0;
    chk("timeout_cycles", n, 10);
    chk("timeout_sum", int'(bus.sum), 15);
    chk("timeout_count", int'(bus.count), 2);
    chk("timeout_to", int'(bus.timed_out), 1);
    tick();
    chk("timeout_to_hold", int'(bus.timed_out), 1);
    chk("timeout_idle_busy", int'(bus.busy), 0);
  endtask

  task automatic test_race_tie;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("tie_to_cleared", int'(bus.timed_out), 0);
    for (int i = 1; i <= 10; i++) begin
      bus.in_valid = i <= 3 || i == 10;
      bus.in = i == 10 ? 4'd2 : 4'd1;
      tick();
      if (i == 9) chk("tie_not_done_early", int'(bus.done), 0);
    end
    bus.in_valid = 1'b0;
    chk("tie_done", int'(bus.done), 1);
    chk("tie_sum", int'(bus.sum), 5);
    chk("tie_count", int'(bus.count), 4);
    chk("tie_to", int'(bus.timed_out), 0);
    tick();
  endtask

  task automatic test_reset_mid_run;
    int seen = 0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.in_valid = 1'b1;
    bus.in = 4'd9;
    tick();
    tick();
    bus.in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({bus.sum, bus.count, bus.busy, bus.done, bus.timed_out} !== '0) begin
      errors++;
      $display("FAIL midrst: got sum=%0d count=%0d busy=%0b done=%0b to=%0b expected all 0",
               bus.sum, bus.count, bus.busy, bus.done, bus.timed_out);
    end
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.done) seen++;
    end
    chk("midrst_no_done", seen, 0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in = 4'd15;
      tick();
    end
    bus.in_valid = 1'b0;
    chk("max_done", int'(bus.done), 1);
    chk("max_sum", int'(bus.sum), 60);
    chk("max_count", int'(bus.count), 4);
    tick();
  endtask

  task automatic test_ignored_inputs;
    bus.in_valid = 1'b1;
    bus.in = 4'd9;
    tick();
    tick();
    tick();
    bus.in_valid = 1'b0;
    chk("idle_sum", int'(bus.sum), 60);
    chk("idle_count", int'(bus.count), 4);
    chk("idle_busy", int'(bus.busy), 0);
    bus.start = 1'b1;
    tick();
    bus.in_valid = 1'b1;
    bus.in = 4'd2;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    chk("run_start_sum", int'(bus.sum), 2);
    chk("run_start_count", int'(bus.count), 1);
    bus.start = 1'b0;
    for (int i = 3; i <= 5; i++) begin
      bus.in_valid = 1'b1;
      bus.in = 4'(i);
      tick();
    end
    chk("ign_done", int'(bus.done), 1);
    chk("ign_sum", int'(bus.sum), 14);
    chk("ign_count", int'(bus.count), 4);
    bus.in = 4'd15;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    chk("done_ign_sum", int'(bus.sum), 14);
    chk("done_ign_count", int'(bus.count), 4);
    chk("done_ign_busy", int'(bus.busy), 0);
    tick();
    chk("done_ign_no_restart", int'(bus.busy), 0);
  endtask

  task automatic test_back_to_back;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in = 4'd1;
      tick();
    end
    bus.in_valid = 1'b0;
    chk("b2b_first_done", int'(bus.done), 1);
    tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("b2b_restart_busy", int'(bus.busy), 1);
    chk("b2b_restart_clear", int'(bus.count), 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    bus.start = 1'b0;
    bus.in = 4'd0;
    bus.in_valid = 1'b0;
    test_reset();
    test_full_burst();
    test_timeout();
    test_race_tie();
    test_reset_mid_run();
    test_ignored_inputs();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/nibble_race_capture.md
# nibble_race_capture

Captures a burst of 4-bit samples from the upstream nibble-producing stage and races the burst against a cycle timeout. Whichever finishes first, the full burst or the timer, ends the window, and the other is cancelled. The block reports the accumulated sum, the beat count and which side won. It sits directly downstream of the clocked nibble transform stage and consumes its 4-bit output.

## Interface
- TIMEOUT, 10: RUN-window length in clock cycles; ≥1.
- BEATS, 4: number of beats that completes a burst; ≥1.
- SUM_W, $clog2(15*BEATS+1): sum width (localparam, derived).
- CNT_W, $clog2(BEATS+1): count width (localparam, derived).

Ports:
- clk  in  1  Single clock; all logic on posedge.
- rst  in  1  Reset, synchronous, active-high.
- start  in  1  Arms a capture window; sampled only in IDLE.
- in  in  4  Upstream nibble.
- in_valid  in  1  `in` is valid this cycle.
- sum  out  SUM_W  Sum of accepted beats in the last or current window.
- count  out  CNT_W  Beats accepted in the last or current window.
- busy  out  1  High in RUN.
- done  out  1  One-cycle pulse, high in DONE state.
- timed_out  out  1  Last window ended by timer; held until next start.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 → RUN.
  - Clear sum, count, timed_out.
  - Load timer with TIMEOUT.
  - in_valid is ignored.
- RUN:
  - Each cycle with in_valid=1: sum += in (zero-extended), count += 1.
  - Timer decrements every RUN cycle.
  - Burst completion: the accepted beat makes count == BEATS → DONE, timed_out=0. The timer is cancelled.
  - Expiry: the TIMEOUT-th RUN cycle ends without completion → DONE, timed_out=1. Any beat valid on that cycle is still accepted.
  - Simultaneous completion and expiry on the same cycle: the data wins, so timed_out=0 and the beat is counted.
  - start is ignored.
  - No beats are accepted after count == BEATS.
- DONE: done=1 for exactly one cycle, then → IDLE unconditionally. in_valid and start are ignored.
- Results: sum, count and timed_out hold their values after DONE until the next accepted start.
- Width: sum never overflows, since the maximum is 15*BEATS (60 at defaults).
- Reset:
  - rst=1 in any state → IDLE on the next edge.
  - sum=0, count=0, busy=0, done=0, timed_out=0, timer cleared.
  - A burst in progress is discarded with no done pulse.

## Timing
- start sampled high at edge k → busy=1 from k+1.
- RUN beats are sampled at edges k+1 … k+TIMEOUT, at most TIMEOUT cycles.
- Finishing edge f (BEATS-th beat or TIMEOUT-th RUN cycle) → done=1 and busy=0 during cycle f+1. sum, count and timed_out are final in that same cycle.
- Back in IDLE at f+2. The earliest next start is sampled at edge f+2.
- Back-to-back windows: period is at least BEATS+2 cycles.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Package `nibble_race_pkg`:
  - State enum `race_state_e` {IDLE, RUN, DONE}.
  - Default constants for TIMEOUT and BEATS.
- Sub-module `race_timer`:
  - Loadable down-counter with ports clk, rst, load, load_val, en, cancel, expired.
  - `expired` is high on the cycle the count reaches 1 with en=1.
  - Top-level FSM, accumulator and counter stay in `nibble_race_capture`.

## Test plan
All scenarios use TIMEOUT=10, BEATS=4.
- Reset: rst high for 2 cycles with in_valid toggling → sum=0, count=0, busy=0, done=0, timed_out=0.
- Full burst: start, then beats 3,4,5,6 on consecutive cycles → done 1 cycle after 4th beat; sum=18, count=4, timed_out=0; done width exactly 1.
- Timeout: start, beats 7,8, then in_valid=0 → done at RUN cycle 10+1; sum=15, count=2, timed_out=1.
- Race tie: start, beats 1,1,1 early, 4th beat (value 2) on RUN cycle 10 → sum=5, count=4, timed_out=0.
- Reset mid-RUN: after 2 beats assert rst → no done pulse, all outputs 0. A new start with 4 beats of 15 → sum=60, count=4.
- Ignored inputs: in_valid=1 in IDLE and DONE, and start pulses during RUN → no change to sum or count and no window restart.
